// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Two-master arbiter in front of a single-port frame-buffer memory.
// The video-in side writes pixels and the VGA scan-out side reads them.
// Reads win by default so the display never starves. A bounded wait
// counter forces a write through after MAX_WAIT refused cycles, so
// video-in can never be locked out.
//
// Handshake (both masters): a request is raised with its address/data and
// held stable until the matching ack is seen high in the same cycle. The
// transfer happens on the rising edge where req && ack. The ack is
// combinational from the current request and the wait counter.
//
// Memory side: one registered command per cycle (mem_en / mem_we /
// mem_addr / mem_wdata). Read data comes back RD_LAT cycles after the
// read command cycle. It is registered into rd_data with a one-cycle
// rd_valid pulse. A shift register of RD_LAT+1 valid bits tracks the
// reads that are in flight, so back-to-back reads return back-to-back
// and in issue order.

module vga_fb_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 24,
  parameter int RD_LAT   = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              aresetn,

  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,

  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Starvation limit expressed in the counter's own 4-bit width.
  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  // Number of consecutive cycles the pending write has been refused.
  logic [3:0] wait_cnt;
  logic       wait_full;

  // Handshake events of the current cycle.
  logic       wr_hs;
  logic       rd_hs;

  // In-flight read tracker: bit k set means a read command was issued
  // k cycles before the current cycle. Bit RD_LAT lines up with mem_rdata.
  logic [RD_LAT:0] rd_pipe;

  assign wait_full = (wait_cnt == WAIT_LIMIT);

  // Grant selection: reads have priority unless the write has waited MAX_WAIT cycles.
  always_comb begin
    wr_ack = 1'b0;
    rd_ack = 1'b0;
    if (aresetn) begin
      if (wr_req && rd_req) begin
        wr_ack = wait_full;
        rd_ack = !wait_full;
      end else begin
        wr_ack = wr_req;
        rd_ack = rd_req;
      end
    end
  end

  assign wr_hs = wr_req && wr_ack;
  assign rd_hs = rd_req && rd_ack;

  // Write wait counter: clear on a write transfer or when no write is pending,
  // otherwise count refused cycles, saturating at the limit.
  always_ff @(posedge clock) begin
    if (!aresetn) begin
      wait_cnt <= 4'd0;
    end else if (!wr_req || wr_hs) begin
      wait_cnt <= 4'd0;
    end else if (!wait_full) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Memory command register: load the granted command, else idle and hold address/data.
  always_ff @(posedge clock) begin
    if (!aresetn) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (wr_hs) begin
      mem_en    <= 1'b1;
      mem_we    <= 1'b1;
      mem_addr  <= wr_addr;
      mem_wdata <= wr_data;
    end else if (rd_hs) begin
      mem_en    <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= rd_addr;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
    end
  end

  // In-flight read tracker: shift in one bit per read transfer; reset drops every pending read.
  always_ff @(posedge clock) begin
    if (!aresetn) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe <= {rd_pipe[RD_LAT-1:0], rd_hs};
    end
  end

  // Read return: capture mem_rdata when the oldest tracked read lines up with it.
  always_ff @(posedge clock) begin
    if (!aresetn) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_pipe[RD_LAT];
      if (rd_pipe[RD_LAT]) begin
        rd_data <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter
// Directed scenarios followed by a randomized traffic phase. A memory model
// answers the DUT's memory port. The reference model predicts each cycle's
// grants, the registered memory command and the read returns. It works from
// an ordered view of the frame buffer: each read sees every write granted
// before it.

module tb_vga_fb_arbiter;

  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 24;
  localparam int RD_LAT   = 2;
  localparam int MAX_WAIT = 4;

  logic              clock;
  logic              aresetn;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  vga_fb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clock(clock), .aresetn(aresetn),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------- clock ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- memory model ----------------
  // Addresses used by the bench stay below 256. The contents start from a
  // fixed pattern (0x10 holds 0xABCDEF) and are overridden by writes.
  logic [DATA_W-1:0] phys_mem [256];
  logic              phys_written [256];
  logic [DATA_W-1:0] rd_line [RD_LAT];

  function automatic logic [DATA_W-1:0] init_val(input int a);
    logic [DATA_W-1:0] h;
    h = 24'(a * 40503 + 24'h5A5A5A);
    return (a == 16) ? 24'hABCDEF : h;
  endfunction

  function automatic logic [DATA_W-1:0] phys_read(input int a);
    return phys_written[a] ? phys_mem[a] : init_val(a);
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) phys_written[i] = 1'b0;
  end

  // The memory performs writes on the command edge and returns read data RD_LAT cycles after the read command cycle.
  always @(posedge clock) begin
    if (mem_en === 1'b1 && mem_we === 1'b1) begin
      phys_mem[int'(mem_addr[7:0])]     <= mem_wdata;
      phys_written[int'(mem_addr[7:0])] <= 1'b1;
    end
    if (mem_en === 1'b1 && mem_we === 1'b0)
      rd_line[0] <= phys_read(int'(mem_addr[7:0]));
    else
      rd_line[0] <= 24'($urandom);
    for (int i = 1; i < RD_LAT; i++) rd_line[i] <= rd_line[i-1];
  end

  assign mem_rdata = rd_line[RD_LAT-1];

  // ---------------- reference model and scoreboard ----------------
  logic [DATA_W-1:0] ref_mem [256];
  logic [DATA_W-1:0] exp_q [$];
  int                ret_q [$];
  int                waited;
  int                cyc;
  logic              exp_en, exp_we, exp_rv;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_wdata, exp_rd_data;
  logic              last_hw, last_hr;
  int                n_checks, n_fail;
  int                n_wr_grants, n_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle. On entry the inputs are set just after a falling edge.
  // The task checks the acks, models the rising edge, then checks the
  // registered outputs at the next falling edge and retires granted requests.
  task automatic tick();
    logic ew, er, hw, hr;
    #1;
    if (!aresetn) begin
      ew = 1'b0; er = 1'b0;
    end else if (wr_req && rd_req) begin
      ew = (waited >= MAX_WAIT);
      er = !ew;
    end else begin
      ew = wr_req; er = rd_req;
    end
    chk("wr_ack", 32'(wr_ack), 32'(ew));
    chk("rd_ack", 32'(rd_ack), 32'(er));
    hw = wr_req && ew;
    hr = rd_req && er;
    @(posedge clock);
    cyc++;
    if (!aresetn) begin
      exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
      exp_rd_data = '0;
      exp_q.delete();
      ret_q.delete();
      waited = 0;
    end else begin
      if (hw) begin
        exp_en = 1'b1; exp_we = 1'b1; exp_addr = wr_addr; exp_wdata = wr_data;
        ref_mem[int'(wr_addr[7:0])] = wr_data;
        n_wr_grants++;
      end else if (hr) begin
        exp_en = 1'b1; exp_we = 1'b0; exp_addr = rd_addr;
        exp_q.push_back(ref_mem[int'(rd_addr[7:0])]);
        // Transfer in cycle cyc-1 returns in cycle (cyc-1)+RD_LAT+2.
        ret_q.push_back(cyc + RD_LAT + 1);
      end else begin
        exp_en = 1'b0; exp_we = 1'b0;
      end
      if (wr_req && !hw) waited = (waited + 1 > MAX_WAIT) ? MAX_WAIT : waited + 1;
      else               waited = 0;
    end
    exp_rv = 1'b0;
    if (ret_q.size() > 0 && ret_q[0] == cyc) begin
      void'(ret_q.pop_front());
      exp_rd_data = exp_q.pop_front();
      exp_rv = 1'b1;
    end
    @(negedge clock);
    chk("mem_en",    32'(mem_en),    32'(exp_en));
    chk("mem_we",    32'(mem_we),    32'(exp_we));
    chk("mem_addr",  32'(mem_addr),  32'(exp_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
    chk("rd_valid",  32'(rd_valid),  32'(exp_rv));
    chk("rd_data",   32'(rd_data),   32'(exp_rd_data));
    if (rd_valid === 1'b1) n_valid++;
    last_hw = hw;
    last_hr = hr;
    if (hw) wr_req = 1'b0;
    if (hr) rd_req = 1'b0;
  endtask

  // Driver: raise new random requests on idle masters with the given percent chance.
  task automatic drive_rand(input int wp, input int rp);
    if (!wr_req && $urandom_range(99) < wp) begin
      wr_req  = 1'b1;
      wr_addr = 19'($urandom_range(255));
      wr_data = 24'($urandom);
    end
    if (!rd_req && $urandom_range(99) < rp) begin
      rd_req  = 1'b1;
      rd_addr = 19'($urandom_range(255));
    end
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    int base;
    n_checks = 0; n_fail = 0; n_wr_grants = 0; n_valid = 0;
    cyc = 0; waited = 0;
    exp_en = 0; exp_we = 0; exp_addr = '0; exp_wdata = '0; exp_rd_data = '0;
    last_hw = 0; last_hr = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    aresetn = 1'b0;
    wr_req = 1'b1; wr_addr = 19'h00055; wr_data = 24'h777777;
    rd_req = 1'b1; rd_addr = 19'h00066;

    // Reset with both requests up: no acks, all registered outputs zero.
    idle(3);
    wr_req = 1'b0; rd_req = 1'b0;
    aresetn = 1'b1;

    // First cycle out of reset: single read of 0x10, returns 0xABCDEF once.
    base = n_valid;
    rd_req = 1'b1; rd_addr = 19'h00010;
    tick();
    chk("first_grant_rd", 32'(last_hr), 32'd1);
    idle(6);
    chk("single_read_pulses", 32'(n_valid - base), 32'd1);

    // Single write to 0x20.
    wr_req = 1'b1; wr_addr = 19'h00020; wr_data = 24'h123456;
    tick();
    chk("single_write_grant", 32'(last_hw), 32'd1);
    idle(2);

    // Both masters always requesting: R,R,R,R,W repeating.
    n_wr_grants = 0;
    for (int i = 0; i < 15; i++) drive_rand(100, 100);
    chk("rw_pattern_writes", 32'(n_wr_grants), 32'd3);
    wr_req = 1'b0; rd_req = 1'b0;
    idle(5);

    // Eight back-to-back reads of addresses 0..7.
    base = n_valid;
    for (int a = 0; a < 8; a++) begin
      rd_req = 1'b1; rd_addr = 19'(a);
      tick();
    end
    idle(5);
    chk("burst_read_pulses", 32'(n_valid - base), 32'd8);

    // Two reads in flight, one reset cycle: nothing returns, then a fresh read works.
    rd_req = 1'b1; rd_addr = 19'h00003; tick();
    rd_req = 1'b1; rd_addr = 19'h00004; tick();
    aresetn = 1'b0; tick();
    aresetn = 1'b1;
    base = n_valid;
    idle(6);
    chk("no_return_after_reset", 32'(n_valid - base), 32'd0);
    rd_req = 1'b1; rd_addr = 19'h00005; tick();
    idle(5);
    chk("read_after_reset", 32'(n_valid - base), 32'd1);

    // Some traffic, then ten idle cycles with held address/data.
    for (int i = 0; i < 20; i++) drive_rand(60, 60);
    wr_req = 1'b0; rd_req = 1'b0;
    idle(10);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      aresetn = ($urandom_range(59) != 0);
      drive_rand($urandom_range(100), $urandom_range(100));
    end
    aresetn = 1'b1;
    wr_req = 1'b0; rd_req = 1'b0;
    idle(RD_LAT + 4);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 19: frame-buffer address width (800x600 words).
REQ-002 Parameter DATA_W, default 24: pixel width, packed {R,G,B} with 8 bits each.
REQ-003 Parameter RD_LAT, default 2: memory read latency, in cycles from the mem_en cycle to the mem_rdata sample; legal range 1..8.
REQ-004 Parameter MAX_WAIT, default 4: write starvation limit, in cycles; legal range 1..15.
REQ-005 clock  in  1  single clock; all logic on rising edge.
REQ-006 aresetn  in  1  reset, synchronous, active-low.
REQ-007 wr_req  in  1  video-in write request; held until acknowledged.
REQ-008 wr_addr  in  ADDR_W  write address; stable while wr_req=1.
REQ-009 wr_data  in  DATA_W  write pixel; stable while wr_req=1.
REQ-010 wr_ack  out  1  combinational write grant; transfer on edge with wr_req&&wr_ack.
REQ-011 rd_req  in  1  VGA read request; held until acknowledged.
REQ-012 rd_addr  in  ADDR_W  read address; stable while rd_req=1.
REQ-013 rd_ack  out  1  combinational read grant; transfer on edge with rd_req&&rd_ack.
REQ-014 rd_valid  out  1  registered one-cycle pulse: rd_data valid.
REQ-015 rd_data  out  DATA_W  registered read pixel.
REQ-016 mem_en  out  1  registered memory command strobe.
REQ-017 mem_we  out  1  registered write enable (1=write, 0=read), meaningful only when mem_en=1.
REQ-018 mem_addr  out  ADDR_W  registered memory address.
REQ-019 mem_wdata  out  DATA_W  registered memory write data.
REQ-020 mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after a read mem_en cycle.

Function
REQ-021 The block SHALL grant at most one of wr_ack/rd_ack per cycle, and SHALL assert neither when its matching request is low.
REQ-022 Only rd_req=1: rd_ack=1. Only wr_req=1: wr_ack=1.
REQ-023 Both requests high with wait_cnt<MAX_WAIT: rd_ack=1 (read priority). Both high with wait_cnt==MAX_WAIT: wr_ack=1 (forced write).
REQ-024 wait_cnt (4 bit): cleared on a write handshake or when wr_req=0; incremented when wr_req=1 and wr_ack=0; saturates at MAX_WAIT.
REQ-025 On a handshake edge, the block SHALL register the command for the next cycle: mem_en=1, mem_we (1 write/0 read), mem_addr, and mem_wdata (write only).
REQ-026 In a cycle following a no-handshake edge, mem_en=0 and mem_we=0; mem_addr and mem_wdata hold their previous values.
REQ-027 A read handshake at edge t gives mem_en=1 in cycle t+1; mem_rdata is sampled RD_LAT cycles later; rd_valid=1 with rd_data in cycle t+RD_LAT+2.
REQ-028 The in-flight read tracker SHALL be a RD_LAT+1 deep valid shift register; back-to-back reads (one per cycle) SHALL produce back-to-back rd_valid pulses in issue order.
REQ-029 rd_data SHALL hold its last value when rd_valid=0.
REQ-030 Interleaved write/read SHALL NOT disturb in-flight read returns; no read-after-write hazard check (memory ordering is the memory's).
REQ-031 Throughput: one memory command per cycle; no idle cycle between consecutive grants.

Reset
REQ-032 While aresetn=0 at an edge: mem_en, mem_we, mem_addr, mem_wdata, rd_valid, rd_data, wait_cnt and the valid pipeline SHALL all be 0.
REQ-033 While aresetn=0: wr_ack=0 and rd_ack=0 regardless of requests.
REQ-034 Reset mid-operation discards all in-flight reads; no rd_valid SHALL be produced for reads issued before reset.
REQ-035 The first grant is possible in the first cycle with aresetn=1.

Verification
REQ-036 rd_req=1, rd_addr=0x00010, memory returns 0xABCDEF, RD_LAT=2 -> mem_en=1/mem_we=0 in cycle 1; rd_valid=1, rd_data=0xABCDEF in cycle 4; single pulse.
REQ-037 wr_req=1, wr_addr=0x00020, wr_data=0x123456, no read -> wr_ack same cycle; next cycle mem_en=1, mem_we=1, mem_addr=0x00020, mem_wdata=0x123456.
REQ-038 rd_req and wr_req held high continuously, MAX_WAIT=4 -> grant pattern R,R,R,R,W repeating; wait_cnt returns to 0 after each W.
REQ-039 rd_req high for 8 consecutive addresses 0..7, RD_LAT=2 -> 8 consecutive rd_valid pulses, data in address order, no gaps.
REQ-040 Two reads in flight, then aresetn=0 for 1 cycle -> no rd_valid afterward; all outputs 0 in the reset cycle; a new read after reset returns normally.
REQ-041 Both requests low for 10 cycles after traffic -> mem_en=0, mem_we=0, mem_addr and mem_wdata unchanged, no acks.
